// File: rtl/tt_sweep_if.sv
// Handshake and data bundle between the sweep controller and the characterisation harness.
// The slave side is the sweep controller; the master side drives requests and the network output.
interface tt_sweep_if #(
    parameter int N_IN = 7,
    parameter int TT_W = 2**N_IN
) ();
    logic              start;
    logic              ready_in;
    logic              abort;
    logic [TT_W-1:0]   expect_tt;
    logic [N_IN-1:0]   x_out;
    logic              f_in;
    logic              busy;
    logic              done_valid;
    logic              done_ready;
    logic [TT_W-1:0]   tt_out;
    logic [N_IN:0]     ones_cnt;
    logic              match;

    modport master (
        output start, abort, expect_tt, f_in, done_ready,
        input  ready_in, x_out, busy, done_valid, tt_out, ones_cnt, match
    );

    modport slave (
        input  start, abort, expect_tt, f_in, done_ready,
        output ready_in, x_out, busy, done_valid, tt_out, ones_cnt, match
    );
endinterface

// File: rtl/tt_sweep_capture.sv
// Exhaustive truth-table extractor: walks every minterm of an N_IN-input network,
// samples its output after SETTLE extra cycles and reports table, popcount and match.
//
//  state   | meaning
//  S_IDLE  | waiting for start, x_out parked at 0, last result on tt_out
//  S_DRIVE | sweeping minterms, holding each for SETTLE+1 cycles
//  S_DONE  | result valid, waiting for done_ready (start+done_ready restarts)
module tt_sweep_capture #(
    parameter int N_IN   = 7,
    parameter int SETTLE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    tt_sweep_if.slave   bus
);
    localparam int TT_W   = 2**N_IN;
    localparam int HOLD_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [N_IN-1:0]   r_idx;
    logic [HOLD_W-1:0] r_hold;
    logic [TT_W-1:0]   r_tt;
    logic [N_IN:0]     r_cnt;
    logic [TT_W-1:0]   r_exp;
    logic              r_match;

    logic              w_accept;
    logic              w_sample;
    logic              w_last;
    logic [TT_W-1:0]   w_tt_next;

    always_comb begin
        w_accept  = ((r_state == S_IDLE) && bus.start)
                 || ((r_state == S_DONE) && bus.done_ready && bus.start);
        w_sample  = (r_state == S_DRIVE) && (r_hold == '0) && !bus.abort;
        w_last    = w_sample && (&r_idx);
        // table is cleared at start, so OR-ing in the sampled bit is enough
        w_tt_next = r_tt | ({{(TT_W-1){1'b0}}, bus.f_in} << r_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        bus.ready_in   = 1'b0;
        bus.busy       = 1'b0;
        bus.done_valid = 1'b0;
        bus.x_out      = '0;
        case (r_state)
            S_IDLE: begin
                bus.ready_in = 1'b1;
                if (bus.start) w_state_next = S_DRIVE;
            end
            S_DRIVE: begin
                bus.busy  = 1'b1;
                bus.x_out = r_idx;
                if (bus.abort)   w_state_next = S_IDLE;
                else if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                bus.done_valid = 1'b1;
                bus.ready_in   = bus.done_ready;
                if (bus.done_ready) w_state_next = bus.start ? S_DRIVE : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_hold  <= '0;
            r_tt    <= '0;
            r_cnt   <= '0;
            r_exp   <= '0;
            r_match <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= '0;
            r_hold  <= HOLD_W'(SETTLE);
            r_tt    <= '0;
            r_cnt   <= '0;
            r_exp   <= bus.expect_tt;
            r_match <= 1'b0;
        end else if (r_state == S_DRIVE) begin
            if (bus.abort) begin
                r_idx   <= '0;
                r_hold  <= '0;
                r_tt    <= '0;
                r_cnt   <= '0;
                r_match <= 1'b0;
            end else if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
            end else begin
                r_tt  <= w_tt_next;
                r_cnt <= r_cnt + {{N_IN{1'b0}}, bus.f_in};
                if (w_last) begin
                    r_idx   <= '0;
                    r_match <= (w_tt_next == r_exp);
                end else begin
                    r_idx  <= r_idx + N_IN'(1);
                    r_hold <= HOLD_W'(SETTLE);
                end
            end
        end
    end

    assign bus.tt_out   = r_tt;
    assign bus.ones_cnt = r_cnt;
    assign bus.match    = r_match;
endmodule

// File: tb/tb_tt_sweep_capture.sv
// Randomised bench for tt_sweep_capture: a combinational network (SETTLE=0) and a
// two-stage registered network (SETTLE=2), checked against tables built from the network's rule.
module tb_tt_sweep_capture;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tt_sweep_if #(.N_IN(7)) if0 ();
    tt_sweep_if #(.N_IN(7)) if2 ();

    tt_sweep_capture #(.N_IN(7), .SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    tt_sweep_capture #(.N_IN(7), .SETTLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

    // network selection: 0 x0, 1 MAJ(x0,x1,x2), 2 const 0, 3 const 1, 4 random lookup table
    int           mode0 = 0;
    int           mode2 = 1;
    logic [127:0] tbl = '0;
    logic         s1, s2;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] TT_X0  = {16{8'hAA}};
    localparam logic [127:0] TT_MAJ = {16{8'hE8}};

    function automatic logic net(int mode, logic [6:0] x, logic [127:0] t);
        case (mode)
            0:       return x[0];
            1:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
            2:       return 1'b0;
            3:       return 1'b1;
            default: return t[x];
        endcase
    endfunction

    always_comb if0.f_in = net(mode0, if0.x_out, tbl);

    always_ff @(posedge clk) begin
        s1 <= net(mode2, if2.x_out, tbl);
        s2 <= s1;
    end
    assign if2.f_in = s2;

    function automatic int popcnt(logic [127:0] v);
        int n = 0;
        for (int i = 0; i < 128; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start0(input logic [127:0] exp);
        @(negedge clk);
        if0.start     = 1'b1;
        if0.expect_tt = exp;
        @(posedge clk);
        #1;
        if0.start = 1'b0;
    endtask

    task automatic wait_done0(output int cyc);
        cyc = 0;
        while (!if0.done_valid && cyc < 1000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic release0();
        @(negedge clk);
        if0.done_ready = 1'b1;
        @(posedge clk);
        #1;
        if0.done_ready = 1'b0;
        check_eq("release_done_valid", 128'(if0.done_valid), 128'd0);
    endtask

    task automatic sweep0(input string tag, input int mode, input logic [127:0] exp_tt,
                          input logic [127:0] exp_in);
        int cyc;
        mode0 = mode;
        start0(exp_in);
        wait_done0(cyc);
        check_eq({tag, "_cycles"}, 128'(cyc), 128'd128);
        check_eq({tag, "_tt"},     if0.tt_out, exp_tt);
        check_eq({tag, "_ones"},   128'(if0.ones_cnt), 128'(popcnt(exp_tt)));
        check_eq({tag, "_match"},  128'(if0.match), 128'(exp_tt == exp_in));
    endtask

    task automatic wait_x0(input logic [6:0] x, output logic timeout);
        int n = 0;
        while (if0.x_out != x && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        timeout = (if0.x_out != x);
    endtask

    initial begin
        logic [127:0] one = 128'd1;
        logic [127:0] exp_v;
        logic [127:0] held_tt;
        logic [7:0]   held_cnt;
        logic         to;
        int           cyc;
        int           bad;

        if0.start = 0; if0.abort = 0; if0.done_ready = 0; if0.expect_tt = '0;
        if2.start = 0; if2.abort = 0; if2.done_ready = 0; if2.expect_tt = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready",  128'(if0.ready_in),   128'd1);
        check_eq("rst_busy",   128'(if0.busy),       128'd0);
        check_eq("rst_valid",  128'(if0.done_valid), 128'd0);
        check_eq("rst_tt",     if0.tt_out,           128'd0);
        check_eq("rst_ones",   128'(if0.ones_cnt),   128'd0);
        check_eq("rst_match",  128'(if0.match),      128'd0);
        check_eq("rst_x",      128'(if0.x_out),      128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // x0 network and majority network, with matching and single-bit-flipped expectations
        sweep0("x0", 0, TT_X0, {$urandom, $urandom, $urandom, $urandom});
        release0();
        check_eq("idle_tt_held", if0.tt_out, TT_X0);
        sweep0("maj", 1, TT_MAJ, TT_MAJ);
        release0();
        sweep0("maj_flip", 1, TT_MAJ, TT_MAJ ^ (one << $urandom_range(127)));
        release0();
        sweep0("zero", 2, 128'd0, 128'd0);
        release0();
        sweep0("ones", 3, ~128'd0, ~128'd0);
        release0();

        // registered network, 3 cycles per minterm
        mode2 = 1;
        @(negedge clk);
        if2.start = 1'b1;
        if2.expect_tt = TT_MAJ;
        @(posedge clk);
        #1;
        if2.start = 1'b0;
        cyc = 0;
        bad = 0;
        while (!if2.done_valid && cyc < 2000) begin
            if (if2.busy && int'(if2.x_out) != cyc / 3) bad++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("s2_cycles", 128'(cyc), 128'd384);
        check_eq("s2_xhold",  128'(bad), 128'd0);
        check_eq("s2_tt",     if2.tt_out, TT_MAJ);
        check_eq("s2_ones",   128'(if2.ones_cnt), 128'd64);
        check_eq("s2_match",  128'(if2.match), 128'd1);
        @(negedge clk);
        if2.done_ready = 1'b1;
        @(posedge clk);
        #1;
        if2.done_ready = 1'b0;

        // abort at minterm 50
        mode0 = 3;
        start0(~128'd0);
        wait_x0(7'd50, to);
        check_eq("wait_x50", 128'(to), 128'd0);
        @(negedge clk);
        if0.abort = 1'b1;
        @(posedge clk);
        #1;
        if0.abort = 1'b0;
        check_eq("abort_busy",  128'(if0.busy),       128'd0);
        check_eq("abort_valid", 128'(if0.done_valid), 128'd0);
        check_eq("abort_tt",    if0.tt_out,           128'd0);
        check_eq("abort_ones",  128'(if0.ones_cnt),   128'd0);
        check_eq("abort_ready", 128'(if0.ready_in),   128'd1);
        repeat (140) @(posedge clk);
        #1;
        check_eq("abort_no_late_valid", 128'(if0.done_valid), 128'd0);

        // abort on the final sample edge wins over completion
        start0(~128'd0);
        repeat (127) @(posedge clk);
        #1;
        check_eq("last_x", 128'(if0.x_out), 128'd127);
        @(negedge clk);
        if0.abort = 1'b1;
        @(posedge clk);
        #1;
        if0.abort = 1'b0;
        check_eq("abort_last_valid", 128'(if0.done_valid), 128'd0);
        check_eq("abort_last_ones",  128'(if0.ones_cnt),   128'd0);

        // reset mid-sweep at minterm 90
        start0(~128'd0);
        wait_x0(7'd90, to);
        check_eq("wait_x90", 128'(to), 128'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_busy",  128'(if0.busy),     128'd0);
        check_eq("rstmid_ones",  128'(if0.ones_cnt), 128'd0);
        check_eq("rstmid_tt",    if0.tt_out,         128'd0);
        check_eq("rstmid_ready", 128'(if0.ready_in), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        tbl = {$urandom, $urandom, $urandom, $urandom};
        sweep0("after_rst", 4, tbl, tbl);

        // results held in DONE; start and abort ignored while done_ready is low
        held_tt  = if0.tt_out;
        held_cnt = if0.ones_cnt;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if0.start = 1'b1;
            if0.abort = 1'($urandom_range(1));
            mode0 = int'($urandom_range(3));
            @(posedge clk);
            #1;
            if (!if0.done_valid || if0.busy || if0.ready_in || if0.tt_out != held_tt
                || if0.ones_cnt != held_cnt || !if0.match) bad++;
        end
        check_eq("done_hold", 128'(bad), 128'd0);
        @(negedge clk);
        if0.abort      = 1'b0;
        mode0          = 1;
        if0.done_ready = 1'b1;
        if0.start      = 1'b1;
        if0.expect_tt  = TT_MAJ;
        #1;
        check_eq("b2b_ready", 128'(if0.ready_in), 128'd1);
        @(posedge clk);
        #1;
        if0.done_ready = 1'b0;
        if0.start      = 1'b0;
        check_eq("b2b_busy",  128'(if0.busy),       128'd1);
        check_eq("b2b_valid", 128'(if0.done_valid), 128'd0);
        check_eq("b2b_ones0", 128'(if0.ones_cnt),   128'd0);
        wait_done0(cyc);
        check_eq("b2b_cycles", 128'(cyc), 128'd128);
        check_eq("b2b_tt",     if0.tt_out, TT_MAJ);
        check_eq("b2b_match",  128'(if0.match), 128'd1);
        release0();

        // random tables, expectation either exact or with one bit flipped
        for (int k = 0; k < 4; k++) begin
            tbl   = {$urandom, $urandom, $urandom, $urandom};
            exp_v = ($urandom_range(1) == 1) ? tbl : (tbl ^ (one << $urandom_range(127)));
            sweep0("rand", 4, tbl, exp_v);
            release0();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
